// File: rtl/rca_pipe.sv
// rca_pipe: STAGES-deep pipelined ripple-carry add/sub (x + y + c_in, or x - y); ovf/zero flags under RCA_PIPE_FLAGS_EN.
// Latency STAGES cycles, one op per cycle; the whole pipe freezes while out_valid && !out_ready, in_ready = !stall.
module rca_pipe #(
    parameter int N      = 16,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         c_in,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         c_out
`ifdef RCA_PIPE_FLAGS_EN
    ,
    output logic         ovf,
    output logic         zero
`endif
);

    localparam int S       = STAGES;
    localparam int W       = N / STAGES;
    localparam int OUT_OFF = W * S * (S - 1) / 2;
    localparam int OPW     = (S > 1) ? OUT_OFF : 1;
    localparam int SMW     = W * S * (S + 1) / 2;

    if (STAGES < 1 || STAGES > N || (N % STAGES) != 0) begin : g_bad_cfg
        $error("rca_pipe: STAGES must divide N and lie in 1..N");
    end

    // Triangular storage, in chunks: level l keeps operand chunks l+1..S-1
    // (still waiting for their carry) and finished sum chunks 0..l.
    function automatic int op_idx(input int l, input int c);
        return l * (S - 1) - (l * (l - 1)) / 2 + (c - l - 1);
    endfunction

    function automatic int sm_idx(input int l, input int c);
        return (l * (l + 1)) / 2 + c;
    endfunction

    logic [S-1:0]   vld_q, vld_d;
    logic [S-1:0]   cy_q, cy_d;
    logic [OPW-1:0] xs_q, xs_d;
    logic [OPW-1:0] ys_q, ys_d;
    logic [SMW-1:0] ss_q, ss_d;
`ifdef RCA_PIPE_FLAGS_EN
    logic           ovf_q, ovf_d;
    logic           zero_q, zero_d;
`endif

    logic [N-1:0] y_eff;
    logic         c_eff;
    logic         stall;
    logic [W-1:0] a, b, sm;
    logic         ci, co;

    assign y_eff    = sub ? ~y : y;
    assign c_eff    = sub ? 1'b1 : c_in;
    assign stall    = vld_q[S-1] & ~out_ready;
    assign in_ready = ~stall;

    always_comb begin
        vld_d = vld_q;
        cy_d  = cy_q;
        xs_d  = xs_q;
        ys_d  = ys_q;
        ss_d  = ss_q;
        a     = '0;
        b     = '0;
        sm    = '0;
        ci    = 1'b0;
        co    = 1'b0;
`ifdef RCA_PIPE_FLAGS_EN
        ovf_d  = ovf_q;
        zero_d = zero_q;
`endif
        if (!stall) begin
            for (int l = 0; l < S; l++) begin
                if (l == 0) begin
                    a        = x[W-1:0];
                    b        = y_eff[W-1:0];
                    ci       = c_eff;
                    vld_d[0] = in_valid;
                end else begin
                    a        = xs_q[op_idx(l-1, l)*W +: W];
                    b        = ys_q[op_idx(l-1, l)*W +: W];
                    ci       = cy_q[l-1];
                    vld_d[l] = vld_q[l-1];
                end
                {co, sm} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
                cy_d[l]  = co;
                ss_d[sm_idx(l, l)*W +: W] = sm;
                for (int c = 0; c < S; c++) begin
                    if (c < l) begin
                        ss_d[sm_idx(l, c)*W +: W] = ss_q[sm_idx(l-1, c)*W +: W];
                    end else if (c > l) begin
                        if (l == 0) begin
                            xs_d[op_idx(0, c)*W +: W] = x[c*W +: W];
                            ys_d[op_idx(0, c)*W +: W] = y_eff[c*W +: W];
                        end else begin
                            xs_d[op_idx(l, c)*W +: W] = xs_q[op_idx(l-1, c)*W +: W];
                            ys_d[op_idx(l, c)*W +: W] = ys_q[op_idx(l-1, c)*W +: W];
                        end
                    end
                end
`ifdef RCA_PIPE_FLAGS_EN
                // a^b^sum at the MSB recovers the carry into it
                if (l == S - 1) begin
                    ovf_d = a[W-1] ^ b[W-1] ^ sm[W-1] ^ co;
                end
`endif
            end
`ifdef RCA_PIPE_FLAGS_EN
            zero_d = (ss_d[OUT_OFF +: N] == '0);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q  <= '0;
            cy_q   <= '0;
            xs_q   <= '0;
            ys_q   <= '0;
            ss_q   <= '0;
`ifdef RCA_PIPE_FLAGS_EN
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
`endif
        end else begin
            vld_q  <= vld_d;
            cy_q   <= cy_d;
            xs_q   <= xs_d;
            ys_q   <= ys_d;
            ss_q   <= ss_d;
`ifdef RCA_PIPE_FLAGS_EN
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
`endif
        end
    end

    assign out_valid = vld_q[S-1];
    assign c_out     = cy_q[S-1];
    assign s         = ss_q[OUT_OFF +: N];
`ifdef RCA_PIPE_FLAGS_EN
    assign ovf  = ovf_q;
    assign zero = zero_q;
`endif

endmodule

// File: tb/tb_rca_pipe.sv
// Directed-vector bench for rca_pipe (N=16, STAGES=4): latency, carries, subtract, streaming, backpressure, reset flush.
module tb_rca_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x, y;
    logic        c_in, sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] s;
    logic        c_out;
`ifdef RCA_PIPE_FLAGS_EN
    logic        ovf, zero;
`endif

    rca_pipe #(.N(16), .STAGES(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .c_in(c_in), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .c_out(c_out)
`ifdef RCA_PIPE_FLAGS_EN
        , .ovf(ovf), .zero(zero)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic        cin;
        logic        sub;
        logic [15:0] es;
        logic        ec;
        logic        eovf;
        logic        ezero;
    } vec_t;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        ovf;
        logic        zero;
    } exp_t;

    vec_t        vt[10];
    exp_t        expq[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] rx, ry, hs;
    logic        rc, rs, hc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", nm, act, req);
        end
    endtask

    function automatic exp_t model(input logic [15:0] xv, input logic [15:0] yv,
                                   input logic ci, input logic sb);
        logic [15:0] ye;
        logic [16:0] r;
        exp_t        e;
        ye     = sb ? ~yv : yv;
        r      = {1'b0, xv} + {1'b0, ye} + {16'b0, (sb ? 1'b1 : ci)};
        e.s    = r[15:0];
        e.c    = r[16];
        e.ovf  = (xv[15] == ye[15]) && (r[15] != xv[15]);
        e.zero = (r[15:0] == 16'h0000);
        return e;
    endfunction

    function automatic exp_t to_exp(input vec_t v);
        exp_t e;
        e.s    = v.es;
        e.c    = v.ec;
        e.ovf  = v.eovf;
        e.zero = v.ezero;
        return e;
    endfunction

    // Scoreboard: every output transfer must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (expq.size() == 0) begin
                chk("unexpected_result", 32'(s), 32'hFFFF_FFFF);
            end else begin
                mon_e = expq.pop_front();
                chk("s", 32'(s), 32'(mon_e.s));
                chk("c_out", 32'(c_out), 32'(mon_e.c));
`ifdef RCA_PIPE_FLAGS_EN
                chk("ovf", 32'(ovf), 32'(mon_e.ovf));
                chk("zero", 32'(zero), 32'(mon_e.zero));
`endif
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 just after the transfer edge.
    task automatic send(input logic [15:0] xv, input logic [15:0] yv,
                        input logic ci, input logic sb, input exp_t e);
        x        = xv;
        y        = yv;
        c_in     = ci;
        sub      = sb;
        in_valid = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 60 && !in_ready; k++) @(negedge clk);
        chk("send_in_ready", 32'(in_ready), 32'd1);
        expq.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic lat_check(input string nm, input vec_t v);
        x        = v.x;
        y        = v.y;
        c_in     = v.cin;
        sub      = v.sub;
        in_valid = 1'b1;
        @(negedge clk);
        chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
        expq.push_back(to_exp(v));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk({nm, "_out_valid"}, 32'(out_valid), 32'(k == 4));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input string nm);
        for (int k = 0; k < 60 && !out_valid; k++) @(negedge clk);
        chk({nm, "_wait_out_valid"}, 32'(out_valid), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //          x         y         cin   sub   s         c     ovf   zero
        vt[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
        vt[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vt[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vt[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vt[4] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vt[5] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vt[6] = '{16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
        vt[7] = '{16'hABCD, 16'hABCD, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vt[8] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0, 1'b0};
        vt[9] = '{16'h1000, 16'h2000, 1'b1, 1'b0, 16'h3001, 1'b0, 1'b0, 1'b0};

        reset     = 1'b1;
        in_valid  = 1'b0;
        x         = '0;
        y         = '0;
        c_in      = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_c_out", 32'(c_out), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("in_ready_after_reset", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        lat_check("lat", vt[0]);
        idle(2);

        for (int i = 0; i < 10; i++) send(vt[i].x, vt[i].y, vt[i].cin, vt[i].sub, to_exp(vt[i]));
        idle(8);

        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    rx = 16'($urandom);
                    ry = 16'($urandom);
                    rc = 1'($urandom_range(0, 1));
                    rs = 1'($urandom_range(0, 1));
                    send(rx, ry, rc, rs, model(rx, ry, rc, rs));
                end
            end
            begin
                wait_out("stream");
                for (int k = 0; k < 20; k++) begin
                    chk("stream_one_per_cycle", 32'(out_valid), 32'd1);
                    @(negedge clk);
                end
            end
        join
        idle(6);

        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    rx = 16'($urandom);
                    ry = 16'($urandom);
                    rc = 1'($urandom_range(0, 1));
                    rs = 1'($urandom_range(0, 1));
                    send(rx, ry, rc, rs, model(rx, ry, rc, rs));
                end
            end
            begin
                wait_out("bp");
                hs = s;
                hc = c_out;
                for (int k = 0; k < 5; k++) begin
                    chk("bp_in_ready", 32'(in_ready), 32'd0);
                    chk("bp_out_valid", 32'(out_valid), 32'd1);
                    chk("bp_s_hold", 32'(s), 32'(hs));
                    chk("bp_c_out_hold", 32'(c_out), 32'(hc));
                    if (k < 4) @(negedge clk);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(12);
        chk("bp_all_delivered", 32'(expq.size()), 32'd0);

        for (int i = 0; i < 3; i++) send(vt[i + 4].x, vt[i + 4].y, vt[i + 4].cin, vt[i + 4].sub, to_exp(vt[i + 4]));
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        expq.delete();
        @(negedge clk);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_s", 32'(s), 32'd0);
        chk("flush_c_out", 32'(c_out), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("flush_no_ghost", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        lat_check("post_reset", vt[3]);
        idle(4);
        chk("queue_empty", 32'(expq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
